mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester arbiter and sequencer sharing one single-port memory between the core's instruction-fetch (IF) path and its load/store (LSU) path. It accepts one request at a time and drives it onto the shared memory port with a req/gnt/rvalid handshake. It routes the response back to the owning requester. LSU has fixed priority over IF, and a starvation counter guarantees IF forward progress.

## Interface
- XLEN, riscv_pkg::XLEN (32): address/data width
- MAX_STARVE, 4: consecutive LSU wins over a waiting IF before IF is forced to win (≥1)

- clk_i  in  1  clock, rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- if_req_i  in  1  IF read request; held until if_gnt_o
- if_addr_i  in  XLEN  IF byte address
- if_gnt_o  out  1  IF request accepted this cycle
- if_rvalid_o  out  1  IF read data valid
- if_rdata_o  out  XLEN  IF read data
- lsu_req_i  in  1  LSU request; held until lsu_gnt_o
- lsu_we_i  in  1  1 = store, 0 = load
- lsu_be_i  in  XLEN/8  byte enables
- lsu_addr_i  in  XLEN  LSU byte address
- lsu_wdata_i  in  XLEN  store data
- lsu_gnt_o  out  1  LSU request accepted this cycle
- lsu_rvalid_o  out  1  LSU response valid (loads and stores)
- lsu_rdata_o  out  XLEN  LSU load data
- mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1/1/XLEN/8/XLEN/XLEN  shared memory request
- mem_gnt_i  in  1  memory accepted mem_req_o
- mem_rvalid_i  in  1  memory response valid, one per accepted request
- mem_rdata_i  in  XLEN  memory response data
- resp_err_o  out  1  one-cycle pulse: mem_rvalid_i outside WAIT
- busy_o  out  1  state ≠ IDLE

## Operation
- FSM states: IDLE, REQ, WAIT.
- **IDLE**
  - Arbitrate. Grant goes to LSU if lsu_req_i, unless IF is requesting and starve_cnt == MAX_STARVE, in which case IF wins. Otherwise grant goes to IF if if_req_i.
  - The winner's gnt_o is asserted combinationally in this cycle (Mealy).
  - At the clock edge the arbiter latches owner, addr, we, be and wdata, then moves to REQ.
  - For IF, latched we = 0 and be = all ones.
- **REQ**
  - mem_* outputs are driven from the latched registers and mem_req_o = 1.
  - mem_req_o and the payload stay stable until mem_gnt_i is sampled high, then the FSM moves to WAIT.
  - No gnt_o is asserted in REQ or WAIT.
- **WAIT**
  - mem_req_o = 0.
  - On mem_rvalid_i, the owner's rvalid_o = 1 and rdata_o = mem_rdata_i, combinational pass-through in the same cycle. The FSM then moves to IDLE.
  - Stores also wait for rvalid; lsu_rdata_o content is don't-care for stores.
- **Non-owner outputs:** the non-owner's rvalid_o is 0. Both rdata_o outputs may carry mem_rdata_i, because only rvalid qualifies them.
- **starve_cnt** (width $clog2(MAX_STARVE+1))
  - Increments on each LSU grant while if_req_i = 1, saturating at MAX_STARVE.
  - Clears on any IF grant, or in any IDLE cycle where if_req_i = 0.
- **resp_err_o:** mem_rvalid_i in IDLE or REQ is ignored by the requesters and pulses resp_err_o for one cycle, registered, one cycle after the stray rvalid.
- **Reset** (asynchronous, including mid-transaction)
  - state = IDLE, starve_cnt = 0, latched payload = 0.
  - mem_req_o, both gnt_o, both rvalid_o, resp_err_o and busy_o are all 0.
  - gnt_o outputs are forced to 0 while rstn_i = 0.
  - An in-flight memory response arriving after reset is treated as stray, so resp_err_o pulses.

## Timing
- Minimum transaction: grant in cycle N (IDLE), mem_req_o in N+1 with mem_gnt_i = 1, rvalid in N+2. That is 3 cycles per transaction and 1 per state.
- Back-to-back: the next grant can occur in the cycle after the rvalid cycle. Maximum throughput is one transaction every 3 cycles.
- Every extra cycle of mem_gnt_i delay adds 1 cycle in REQ, and every extra cycle of rvalid delay adds 1 cycle in WAIT.
- Combinational paths:
  - req_i → gnt_o (IDLE only)
  - mem_rvalid_i/mem_rdata_i → rvalid_o/rdata_o (WAIT only)
- All mem_* outputs are registered.

## Structure
- riscv_pkg gains:
  - arb_state_e {ARB_IDLE, ARB_REQ, ARB_WAIT}
  - arb_owner_e {OWNER_IF, OWNER_LSU}
  - a mem_req_t packed struct {we, be, addr, wdata}, used for the latched payload
- No sub-module: the FSM, the starvation counter and the payload register are all inline, about 200 lines.

## Test plan
1. **Lone IF read:** if_req_i = 1 with if_addr_i = 0x40 → if_gnt_o in cycle N. In N+1, mem_req_o = 1, mem_addr_o = 0x40, mem_we_o = 0, mem_be_o = 0xF. Return mem_gnt_i = 1 and then mem_rdata_i = 0xDEADBEEF in N+2 → if_rvalid_o = 1 with if_rdata_o = 0xDEADBEEF.
2. **Simultaneous requests:** IF read of 0x80 and LSU store to 0x100 (wdata 0x12345678, be 0x3) → LSU granted first, with mem_we_o = 1, mem_be_o = 0x3 and mem_wdata_o = 0x12345678. After its rvalid, IF is granted in the next IDLE cycle.
3. **Starvation:** MAX_STARVE = 4, LSU and IF requesting continuously → exactly 4 LSU grants, then 1 IF grant, then starve_cnt = 0 and LSU wins again.
4. **Memory backpressure:** mem_gnt_i held low 3 cycles → mem_req_o and all payload signals stable for 4 cycles, and no gnt_o asserted while busy_o = 1.
5. **Reset mid-transaction:** rstn_i low during WAIT → all outputs 0 immediately. After rstn_i goes high, a stale mem_rvalid_i → no rvalid_o, resp_err_o = 1 for exactly one cycle.
6. **Stray response:** mem_rvalid_i = 1 while in REQ → resp_err_o pulses, the FSM stays in REQ, and the real response after mem_gnt_i is delivered normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared core types: data width and the memory-port arbiter's state,
// owner and latched-request types.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    // Arbiter sequencing states: arbitrate, present request, await response.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_REQ  = 2'd1,
        ARB_WAIT = 2'd2
    } arb_state_e;

    // Requester that owns the transaction in flight.
    typedef enum logic {
        OWNER_IF  = 1'b0,
        OWNER_LSU = 1'b1
    } arb_owner_e;

    // Request payload captured at grant time and replayed on the memory port.
    typedef struct packed {
        logic                we;
        logic [XLEN/8-1:0]   be;
        logic [XLEN-1:0]     addr;
        logic [XLEN-1:0]     wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-requester (IF / LSU) arbiter and sequencer for one single-port memory.
// LSU has fixed priority; a saturating starvation counter forces an IF win
// after MAX_STARVE consecutive LSU grants taken while IF was waiting.
// The payload type comes from riscv_pkg, so XLEN must match riscv_pkg::XLEN.
module mem_port_arbiter
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN       = riscv_pkg::XLEN,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,

    input  logic              if_req_i,
    input  logic [XLEN-1:0]   if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [XLEN-1:0]   if_rdata_o,

    input  logic              lsu_req_i,
    input  logic              lsu_we_i,
    input  logic [XLEN/8-1:0] lsu_be_i,
    input  logic [XLEN-1:0]   lsu_addr_i,
    input  logic [XLEN-1:0]   lsu_wdata_i,
    output logic              lsu_gnt_o,
    output logic              lsu_rvalid_o,
    output logic [XLEN-1:0]   lsu_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,

    output logic              resp_err_o,
    output logic              busy_o
);

    localparam int unsigned STARVE_W = $clog2(MAX_STARVE + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(MAX_STARVE);

    arb_state_e          state_q,    state_d;
    arb_owner_e          owner_q,    owner_d;
    mem_req_t            payload_q,  payload_d;
    logic [STARVE_W-1:0] starve_q,   starve_d;
    logic                mem_req_q,  mem_req_d;
    logic                busy_q,     busy_d;
    logic                resp_err_q, resp_err_d;

    logic                lsu_win_s;
    logic                if_win_s;
    logic                if_gnt_s;
    logic                lsu_gnt_s;
    logic                if_rvalid_s;
    logic                lsu_rvalid_s;

    // Priority decision: LSU wins unless a waiting IF has hit the starvation limit.
    always_comb begin
        lsu_win_s = 1'b0;
        if_win_s  = 1'b0;
        if (if_req_i && (starve_q == STARVE_MAX)) begin
            if_win_s = 1'b1;
        end else if (lsu_req_i) begin
            lsu_win_s = 1'b1;
        end else if (if_req_i) begin
            if_win_s = 1'b1;
        end else begin
            if_win_s  = 1'b0;
            lsu_win_s = 1'b0;
        end
    end

    // Next-state, payload capture, starvation tracking and Mealy grant/response outputs.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        payload_d    = payload_q;
        starve_d     = starve_q;
        if_gnt_s     = 1'b0;
        lsu_gnt_s    = 1'b0;
        if_rvalid_s  = 1'b0;
        lsu_rvalid_s = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (lsu_win_s) begin
                    lsu_gnt_s       = 1'b1;
                    owner_d         = OWNER_LSU;
                    payload_d.we    = lsu_we_i;
                    payload_d.be    = lsu_be_i;
                    payload_d.addr  = lsu_addr_i;
                    payload_d.wdata = lsu_wdata_i;
                    state_d         = ARB_REQ;
                    if (if_req_i) begin
                        if (starve_q == STARVE_MAX) begin
                            starve_d = starve_q;
                        end else begin
                            starve_d = starve_q + STARVE_W'(1);
                        end
                    end else begin
                        starve_d = '0;
                    end
                end else if (if_win_s) begin
                    if_gnt_s        = 1'b1;
                    owner_d         = OWNER_IF;
                    payload_d.we    = 1'b0;
                    payload_d.be    = '1;
                    payload_d.addr  = if_addr_i;
                    payload_d.wdata = '0;
                    state_d         = ARB_REQ;
                    starve_d        = '0;
                end else begin
                    // Nobody requesting, so IF is not waiting either.
                    starve_d = '0;
                end
            end
            ARB_REQ: begin
                if (mem_gnt_i) begin
                    state_d = ARB_WAIT;
                end else begin
                    state_d = ARB_REQ;
                end
            end
            ARB_WAIT: begin
                if (mem_rvalid_i) begin
                    if (owner_q == OWNER_LSU) begin
                        lsu_rvalid_s = 1'b1;
                    end else begin
                        if_rvalid_s  = 1'b1;
                    end
                    state_d = ARB_IDLE;
                end else begin
                    state_d = ARB_WAIT;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Registered-output next values: memory request, busy flag, stray-response flag.
    always_comb begin
        mem_req_d  = (state_d == ARB_REQ);
        busy_d     = (state_d != ARB_IDLE);
        resp_err_d = mem_rvalid_i && (state_q != ARB_WAIT);
    end

    // State, payload, counter and registered-output flops with async reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ARB_IDLE;
            owner_q    <= OWNER_IF;
            payload_q  <= '0;
            starve_q   <= '0;
            mem_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            payload_q  <= payload_d;
            starve_q   <= starve_d;
            mem_req_q  <= mem_req_d;
            busy_q     <= busy_d;
            resp_err_q <= resp_err_d;
        end
    end

    // Grants are gated by reset so nothing is accepted while the block is held in reset.
    assign if_gnt_o     = if_gnt_s  & rstn_i;
    assign lsu_gnt_o    = lsu_gnt_s & rstn_i;
    assign if_rvalid_o  = if_rvalid_s;
    assign lsu_rvalid_o = lsu_rvalid_s;
    // Read data is qualified only by rvalid, so both sides see the memory bus.
    assign if_rdata_o   = mem_rdata_i;
    assign lsu_rdata_o  = mem_rdata_i;

    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = payload_q.we;
    assign mem_be_o     = payload_q.be;
    assign mem_addr_o   = payload_q.addr;
    assign mem_wdata_o  = payload_q.wdata;

    assign resp_err_o   = resp_err_q;
    assign busy_o       = busy_q;

endmodule
